// File: rtl/rand_stat_mon.sv
// rand_stat_mon: windowed statistics monitor for a real-valued sample stream.
// Publishes count, mean, min, max, out-of-range count and histogram per window.
module rand_stat_mon #(
    parameter int WINDOW = 1000,
    parameter int NBINS  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sample_valid,
    input  real                    sample_in,
    output logic                   busy,
    output logic                   window_done,
    output logic [CNT_W-1:0]       sample_count,
    output real                    mean_out,
    output real                    min_out,
    output real                    max_out,
    output logic [CNT_W-1:0]       oor_count,
    output logic [NBINS*CNT_W-1:0] hist_flat
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t state, state_nx;

    logic [NBINS-1:0][CNT_W-1:0] hist;

    real  sum_r, min_r, max_r;
    real  new_sum, new_min, new_max;
    logic accept, last, first, oor;
    int   bin_idx;

    assign hist_flat = hist;

    always_comb begin
        accept  = (state == ACCUM) && sample_valid;
        last    = accept && (sample_count == CNT_W'(WINDOW - 1));
        first   = (sample_count == '0);
        oor     = (sample_in < 0.0) || (sample_in >= 1.0);
        new_sum = sum_r + sample_in;
        new_min = (first || (sample_in < min_r)) ? sample_in : min_r;
        new_max = (first || (sample_in > max_r)) ? sample_in : max_r;
        bin_idx = 0;
        // clamp guards x*NBINS rounding up to NBINS for x just below 1.0
        if (!oor) begin
            bin_idx = $rtoi(sample_in * real'(NBINS));
            if (bin_idx > NBINS - 1) bin_idx = NBINS - 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        window_done = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nx = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (last) state_nx = REPORT;
            end
            REPORT: begin
                window_done = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_count <= '0;
            oor_count    <= '0;
            hist         <= '0;
            sum_r        <= 0.0;
            min_r        <= 0.0;
            max_r        <= 0.0;
            mean_out     <= 0.0;
            min_out      <= 0.0;
            max_out      <= 0.0;
        end else if (state == IDLE && start) begin
            sample_count <= '0;
            oor_count    <= '0;
            hist         <= '0;
            sum_r        <= 0.0;
        end else if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            sum_r        <= new_sum;
            min_r        <= new_min;
            max_r        <= new_max;
            if (oor) begin
                if (oor_count != '1) oor_count <= oor_count + CNT_W'(1);
            end else begin
                for (int b = 0; b < NBINS; b++) begin
                    if (b == bin_idx && hist[b] != '1)
                        hist[b] <= hist[b] + CNT_W'(1);
                end
            end
            // results land with the window-closing sample so REPORT sees them
            if (last) begin
                mean_out <= new_sum / real'(WINDOW);
                min_out  <= new_min;
                max_out  <= new_max;
            end
        end
    end

endmodule
